alu_dispatch: RTL and testbench
===============================

// Module: alu_dispatch
// PURPOSE
// - Issue/retire stage wrapped around alu_comb; one instance per ALU execution unit.
// - Accepts ops over a valid/ready handshake and decodes a 4-bit opcode into the 8-bit ALU ctrl word.
// - Sequences double-width ops as two ALU beats, chaining carry between them.
// - Registers the result and presents it downstream on a second valid/ready handshake.
// PARAMETERS
// - DATA_WIDTH  16  ALU datapath width; operands/result ports are 2*DATA_WIDTH
// PORTS
// - clk        in   1     clock, all logic on rising edge
// - reset_n    in   1     synchronous active-low reset
// - in_valid   in   1     op request valid
// - in_ready   out  1     stage can accept op
// - in_op      in   4     opcode (see BEHAVIOUR)
// - in_a       in   2*DW  operand A (narrow ops use [DW-1:0])
// - in_b       in   2*DW  operand B (narrow ops use [DW-1:0])
// - alu_a      out  DW    to alu_comb.a
// - alu_b      out  DW    to alu_comb.b
// - alu_ctrl   out  8     to alu_comb.ctrl
// - alu_cin    out  1     to alu_comb.cin
// - alu_out_en out  1     to alu_comb.out_en
// - alu_out    in   DW    from alu_comb.out
// - alu_cout   in   1     from alu_comb.cout
// - res_valid  out  1     result valid
// - res_ready  in   1     downstream accepts result
// - res_data   out  2*DW  result; narrow ops zero-extended
// - res_cout   out  1     carry out of final beat (SUB: 1 = no borrow)
// - res_err    out  1     illegal opcode, res_data=0
// BEHAVIOUR
// - Opcode -> ctrl / cin:
//   - 0 ADD  8'h2C, cin 0.
//   - 1 SUB  8'hAC, cin 1.
//   - 2 AND  8'h22.
//   - 3 OR   8'h32.
//   - 4 XOR  8'h04.
//   - 5 NOT  8'h45.
//   - 6 MOV  8'h44.
//   - 7 ADDC 8'h2C, cin = cflag.
//   - 8 SUBB 8'hAC, cin = cflag.
//   - 9 ADDW 8'h2C, two beats.
//   - 10 SUBW 8'hAC, two beats.
//   - 11-15 illegal.
//   - Logic ops (2-6) drive cin 0.
// - FSM states: IDLE, LO, HI, ERR, HOLD.
//   - IDLE: in_ready=1. Accept -> LO, or -> ERR if illegal; capture op/operands.
//   - LO: drive the low halves, out_en=1. Capture alu_out into res_data[DW-1:0].
//     - Capture alu_cout into the carry register.
//     - Next state is HI if the op is ADDW/SUBW, else HOLD.
//   - HI: drive the upper halves; cin = LO-beat cout registered; capture into res_data[2DW-1:DW]. Next state HOLD.
//   - ERR: set res_err=1, res_data=0, res_cout=0. Next state HOLD.
//   - HOLD: res_valid=1 and outputs stable until res_ready.
//     - On res_ready: clear res_valid.
//     - in_ready=res_ready in HOLD; a simultaneous accept goes straight to LO/ERR, else to IDLE.
// - Latency from accept cycle N: narrow/illegal res_valid at N+2; wide at N+3. Best throughput 1 op / 2 cycles (narrow).
// - Outside LO/HI: alu_out_en=0, alu_a=alu_b=0, alu_ctrl=0, alu_cin=0.
// - Reset (any state, incl. mid-wide-op): go to IDLE and discard the in-flight op.
//   - res_valid=0, res_data=0, res_cout=0, res_err=0, cflag=0.
//   - in_ready=1 from the first cycle after reset release.
// - Widths: all arithmetic mod 2^DW per beat. Wide SUB borrow is propagated via the HI cin.
// - cflag is updated on HOLD entry by arithmetic ops (0,1,7-10), with the final-beat cout. Logic and illegal ops leave cflag unchanged.
// CONFIGURATION
// - ALU_DISPATCH_CFLAG_EN defined: cflag register present; ADDC/SUBB legal as above.
// - ALU_DISPATCH_CFLAG_EN undefined: no cflag; opcodes 7,8 are illegal (ERR path, res_err=1). All other behaviour identical.
// TESTING
// - DW=16, ADD a=16'hFFFF b=1 -> res_valid at N+2, res_data=0, res_cout=1.
// - SUB a=5 b=7 -> res_data=16'hFFFE, res_cout=0. Then with macro: SUBB a=0 b=0 -> res_data=16'hFFFF.
// - ADDW a=32'h0000_FFFF b=1 -> LO cout 1 feeds HI cin; res_data=32'h0001_0000 at N+3, res_cout=0.
// - AND/OR/XOR/NOT/MOV on a=16'hF0F0 b=16'hFF00 -> 16'hF000 / FFF0 / 0FF0 / 0F0F / F0F0.
// - in_op=12 -> res_err=1, res_data=0, cflag unchanged. Hold res_ready=0 for 5 cycles: outputs stable, in_ready=0.
// - Back-to-back with res_ready=1 -> new op accepted in HOLD cycle. Assert reset_n=0 during HI -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/alu_dispatch.sv
// Issue/retire stage around alu_comb: decodes ops, sequences wide ops as two beats, holds the result.
// Optional ALU_DISPATCH_CFLAG_EN adds the carry-flag register and enables ADDC/SUBB.
module alu_dispatch #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [2*DATA_WIDTH-1:0] in_a,
  input  logic [2*DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [7:0]              alu_ctrl,
  output logic                    alu_cin,
  output logic                    alu_out_en,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  input  logic                    alu_cout,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    res_cout,
  output logic                    res_err
);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, LO, HI, ERR, HOLD} state_t;
  typedef struct packed {
    logic [3:0]      op;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
  } req_t;

  state_t state, state_nx;
  req_t   req_q;
  logic   carry_q;
  logic   cflag;
  logic   accept, illegal_in, is_wide, is_arith;
  logic [7:0] dec_ctrl;
  logic       dec_cin;

`ifdef ALU_DISPATCH_CFLAG_EN
  logic cflag_q;
  assign cflag = cflag_q;
`else
  assign cflag = 1'b0;
`endif

  assign in_ready  = (state == IDLE) || (state == HOLD && res_ready);
  assign res_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign is_wide   = (req_q.op == 4'd9) || (req_q.op == 4'd10);
  assign is_arith  = (req_q.op <= 4'd1) || ((req_q.op >= 4'd7) && (req_q.op <= 4'd10));

  always_comb begin
    illegal_in = (in_op > 4'd10);
`ifndef ALU_DISPATCH_CFLAG_EN
    if (in_op == 4'd7 || in_op == 4'd8) illegal_in = 1'b1;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = illegal_in ? ERR : LO;
      LO:   state_nx = is_wide ? HI : HOLD;
      HI:   state_nx = HOLD;
      ERR:  state_nx = HOLD;
      HOLD: if (res_ready) state_nx = accept ? (illegal_in ? ERR : LO) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Low-beat decode; the high beat reuses ctrl and takes cin from the LO carry.
  always_comb begin
    dec_ctrl = 8'h00;
    dec_cin  = 1'b0;
    case (req_q.op)
      4'd0, 4'd9:  dec_ctrl = 8'h2C;
      4'd1, 4'd10: begin dec_ctrl = 8'hAC; dec_cin = 1'b1; end
      4'd2:        dec_ctrl = 8'h22;
      4'd3:        dec_ctrl = 8'h32;
      4'd4:        dec_ctrl = 8'h04;
      4'd5:        dec_ctrl = 8'h45;
      4'd6:        dec_ctrl = 8'h44;
      4'd7:        begin dec_ctrl = 8'h2C; dec_cin = cflag; end
      4'd8:        begin dec_ctrl = 8'hAC; dec_cin = cflag; end
      default:     dec_ctrl = 8'h00;
    endcase
  end

  always_comb begin
    alu_out_en = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = 8'h00;
    alu_cin    = 1'b0;
    if (state == LO) begin
      alu_out_en = 1'b1;
      alu_a      = req_q.a[DW-1:0];
      alu_b      = req_q.b[DW-1:0];
      alu_ctrl   = dec_ctrl;
      alu_cin    = dec_cin;
    end else if (state == HI) begin
      alu_out_en = 1'b1;
      alu_a      = req_q.a[2*DW-1:DW];
      alu_b      = req_q.b[2*DW-1:DW];
      alu_ctrl   = dec_ctrl;
      alu_cin    = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      req_q    <= '0;
      carry_q  <= 1'b0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_err  <= 1'b0;
`ifdef ALU_DISPATCH_CFLAG_EN
      cflag_q  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) req_q <= '{op: in_op, a: in_a, b: in_b};
      case (state)
        LO: begin
          res_data <= {{DW{1'b0}}, alu_out};
          res_cout <= alu_cout;
          res_err  <= 1'b0;
          carry_q  <= alu_cout;
`ifdef ALU_DISPATCH_CFLAG_EN
          if (is_arith && !is_wide) cflag_q <= alu_cout;
`endif
        end
        HI: begin
          res_data[2*DW-1:DW] <= alu_out;
          res_cout            <= alu_cout;
`ifdef ALU_DISPATCH_CFLAG_EN
          cflag_q             <= alu_cout;
`endif
        end
        ERR: begin
          res_data <= '0;
          res_cout <= 1'b0;
          res_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural alu_comb stand-in; handles both cflag builds.
module tb_alu_dispatch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [7:0]  alu_ctrl;
  logic        alu_cin, alu_out_en, alu_cout;
  logic        res_valid, res_ready = 1'b0, res_cout, res_err;
  logic [31:0] res_data;
  int total = 0, bad = 0;

  alu_dispatch #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
    .alu_out_en(alu_out_en), .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // alu_comb stand-in: subtract is a + ~b + cin.
  logic [16:0] sum;
  always_comb begin
    sum = '0;
    case (alu_ctrl)
      8'h2C: sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      8'hAC: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_cin};
      8'h22: sum = {1'b0, alu_a & alu_b};
      8'h32: sum = {1'b0, alu_a | alu_b};
      8'h04: sum = {1'b0, alu_a ^ alu_b};
      8'h45: sum = {1'b0, ~alu_a};
      8'h44: sum = {1'b0, alu_a};
      default: sum = '0;
    endcase
    if (!alu_out_en) sum = '0;
  end
  assign alu_out  = sum[15:0];
  assign alu_cout = sum[16];

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one op for a single cycle; caller ensures in_ready is high.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if ({res_valid, res_cout, res_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {res_valid, res_cout, res_err}); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", res_data); end
    total++; if ({alu_out_en, alu_ctrl} !== 9'h0) begin bad++; $display("FAIL reset_alu got=%h want=0", {alu_out_en, alu_ctrl}); end
  endtask

  task automatic test_add();
    send(4'd0, 32'h0000_FFFF, 32'h1);
    total++; if ({alu_out_en, alu_ctrl, alu_cin} !== {1'b1, 8'h2C, 1'b0}) begin bad++; $display("FAIL add_lo_drive got=%b/%h/%b want=1/2c/0", alu_out_en, alu_ctrl, alu_cin); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b want=0", res_valid); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", res_valid); end
    total++; if ({res_data, res_cout, res_err} !== {32'h0, 1'b1, 1'b0}) begin bad++; $display("FAIL add_result got=%h/%b/%b want=0/1/0", res_data, res_cout, res_err); end
    total++; if ({alu_out_en, alu_a, alu_ctrl} !== 25'h0) begin bad++; $display("FAIL add_hold_alu_idle got=%b/%h/%h want=0", alu_out_en, alu_a, alu_ctrl); end
    pop();
  endtask

  task automatic test_sub();
    send(4'd1, 32'h5, 32'h7);
    step();
    total++; if ({res_valid, res_data, res_cout} !== {1'b1, 32'h0000_FFFE, 1'b0}) begin bad++; $display("FAIL sub_result got=%b/%h/%b want=1/0000fffe/0", res_valid, res_data, res_cout); end
    pop();
    send(4'd8, 32'h0, 32'h0);
    step();
`ifdef ALU_DISPATCH_CFLAG_EN
    total++; if ({res_err, res_data} !== {1'b0, 32'h0000_FFFF}) begin bad++; $display("FAIL subb_result got=%b/%h want=0/0000ffff", res_err, res_data); end
`else
    total++; if ({res_err, res_data} !== {1'b1, 32'h0}) begin bad++; $display("FAIL subb_illegal got=%b/%h want=1/0", res_err, res_data); end
`endif
    pop();
  endtask

  task automatic test_wide();
    send(4'd9, 32'h0000_FFFF, 32'h1);
    total++; if ({alu_a, alu_b} !== {16'hFFFF, 16'h0001}) begin bad++; $display("FAIL addw_lo_ops got=%h/%h want=ffff/0001", alu_a, alu_b); end
    step();
    total++; if ({res_valid, alu_out_en, alu_cin, alu_a} !== {1'b0, 1'b1, 1'b1, 16'h0}) begin bad++; $display("FAIL addw_hi_drive got=%b/%b/%b/%h want=0/1/1/0", res_valid, alu_out_en, alu_cin, alu_a); end
    step();
    total++; if ({res_valid, res_data, res_cout} !== {1'b1, 32'h0001_0000, 1'b0}) begin bad++; $display("FAIL addw_result got=%b/%h/%b want=1/00010000/0", res_valid, res_data, res_cout); end
    pop();
    send(4'd10, 32'h0001_0000, 32'h1);
    step();
    total++; if ({alu_ctrl, alu_cin, alu_a} !== {8'hAC, 1'b0, 16'h0001}) begin bad++; $display("FAIL subw_hi_drive got=%h/%b/%h want=ac/0/0001", alu_ctrl, alu_cin, alu_a); end
    step();
    total++; if ({res_valid, res_data, res_cout} !== {1'b1, 32'h0000_FFFF, 1'b1}) begin bad++; $display("FAIL subw_result got=%b/%h/%b want=1/0000ffff/1", res_valid, res_data, res_cout); end
    pop();
  endtask

  task automatic test_logic();
    logic [3:0]  ops [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [15:0] exp [5] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F, 16'hF0F0};
    for (int i = 0; i < 5; i++) begin
      send(ops[i], 32'hF0F0, 32'hFF00);
      step();
      total++; if ({res_valid, res_err, res_data} !== {1'b1, 1'b0, 16'h0, exp[i]}) begin bad++; $display("FAIL logic_op%0d got=%b/%b/%h want=1/0/%h", ops[i], res_valid, res_err, res_data, {16'h0, exp[i]}); end
      pop();
    end
  endtask

  task automatic test_illegal();
    send(4'd0, 32'hFFFF, 32'h1);
    step(); pop();
    send(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if ({res_valid, res_err, res_data, res_cout, in_ready} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin bad++; $display("FAIL illegal_hold%0d got=%b/%b/%h/%b/%b want=1/1/0/0/0", i, res_valid, res_err, res_data, res_cout, in_ready); end
      step();
    end
    pop();
    send(4'd7, 32'h0, 32'h0);
    step();
`ifdef ALU_DISPATCH_CFLAG_EN
    total++; if ({res_err, res_data, res_cout} !== {1'b0, 32'h1, 1'b0}) begin bad++; $display("FAIL addc_cflag_kept got=%b/%h/%b want=0/1/0", res_err, res_data, res_cout); end
`else
    total++; if ({res_err, res_data} !== {1'b1, 32'h0}) begin bad++; $display("FAIL addc_illegal got=%b/%h want=1/0", res_err, res_data); end
`endif
    pop();
  endtask

  task automatic test_back_to_back();
    send(4'd0, 32'h1, 32'h2);
    step();
    total++; if ({res_valid, res_data} !== {1'b1, 32'h3}) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/3", res_valid, res_data); end
    res_ready = 1'b1; in_valid = 1'b1; in_op = 4'd4; in_a = 32'h3; in_b = 32'h5;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; res_ready = 1'b0;
    total++; if ({res_valid, alu_ctrl} !== {1'b0, 8'h04}) begin bad++; $display("FAIL b2b_lo got=%b/%h want=0/04", res_valid, alu_ctrl); end
    step();
    total++; if ({res_valid, res_data} !== {1'b1, 32'h6}) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/6", res_valid, res_data); end
    pop();
  endtask

  task automatic test_reset_mid();
    send(4'd10, 32'h0001_0000, 32'h1);
    step();
    total++; if (alu_a !== 16'h0001) begin bad++; $display("FAIL mid_in_hi got=%h want=0001", alu_a); end
    reset_n = 1'b0;
    step();
    total++; if ({in_ready, res_valid, res_err, res_cout, res_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL mid_reset_outs got=%b/%b/%b/%b/%h want=1/0/0/0/0", in_ready, res_valid, res_err, res_cout, res_data); end
    total++; if ({alu_out_en, alu_ctrl, alu_a, alu_b, alu_cin} !== 42'h0) begin bad++; $display("FAIL mid_reset_alu got=%b/%h/%h/%h/%b want=0", alu_out_en, alu_ctrl, alu_a, alu_b, alu_cin); end
    reset_n = 1'b1;
    step();
    total++; if ({in_ready, res_valid} !== 2'b10) begin bad++; $display("FAIL mid_after got=%b want=10", {in_ready, res_valid}); end
  endtask

  initial begin
    step();
    test_reset();
    test_add();
    test_sub();
    test_wide();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
